// File: rtl/uc_rr_sched.sv
// uc_rr_sched -- round-robin collector for per-engine unit-clause queues.
//
// Pops at most one implied literal per cycle from the engine UC output
// queues and forwards it on a single registered literal stream feeding the
// unit-clause arbiter's PQ-mode input. A conflict freezes all traffic until
// reset.
//
// Ports:
//   clk, rst      clock (rising edge), asynchronous active-high reset
//   start, stop   run control pulses (IDLE->RUN, RUN->DRAIN)
//   conflict      conflict flag from the UC arbiter
//   eng_empty     per-engine queue empty flags
//   eng_lit       show-ahead head literal, engine i at [i*LIT_W +: LIT_W]
//   eng_pop       one-hot (or zero) combinational pop strobe
//   out_valid, out_lit, out_ready   registered output literal stream
//   grant_idx     last granted engine
//   busy, halted  state is RUN/DRAIN, state is HALT
//   fwd_cnt       literals accepted downstream since last start (saturating)
//
// Build option:
//   UC_RR_SCHED_DEDUP_EN  suppress forwarding of a granted literal equal to
//                         the last literal loaded into the output register.
//
// state | meaning
// IDLE  | waiting for start, output stream empty
// RUN   | granting engines round-robin into the output register
// DRAIN | no new pops, waiting for the pending literal to be accepted
// HALT  | conflict seen, everything frozen until reset

module uc_rr_sched #(
  parameter int NUM_ENG = 4,
  parameter int LIT_W   = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        stop,
  input  logic                        conflict,
  input  logic [NUM_ENG-1:0]          eng_empty,
  input  logic [NUM_ENG*LIT_W-1:0]    eng_lit,
  output logic [NUM_ENG-1:0]          eng_pop,
  output logic                        out_valid,
  output logic [LIT_W-1:0]            out_lit,
  input  logic                        out_ready,
  output logic [$clog2(NUM_ENG)-1:0]  grant_idx,
  output logic                        busy,
  output logic                        halted,
  output logic [15:0]                 fwd_cnt
);

  localparam int IDX_W = $clog2(NUM_ENG);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_HALT} state_t;

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   rr_ptr;
  logic [NUM_ENG-1:0] req;
  logic               found;
  logic [IDX_W-1:0]   sel;
  logic [LIT_W-1:0]   sel_lit;
  logic [LIT_W-1:0]   lit_arr [NUM_ENG];
  logic               slot_free;
  logic               hs;
  logic               dup;
  logic               grant;
  logic               load;
  logic               valid_nxt;
  logic               cnt_clr;
  logic               cnt_inc;

  // (base + ofs) mod NUM_ENG, valid for base, ofs < NUM_ENG
  function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base, input int ofs);
    int s;
    s = int'(base) + ofs;
    if (s >= NUM_ENG) s = s - NUM_ENG;
    return IDX_W'(s);
  endfunction

  for (genvar g = 0; g < NUM_ENG; g++) begin : g_lit
    assign lit_arr[g] = eng_lit[g*LIT_W +: LIT_W];
  end

  assign req       = ~eng_empty;
  assign slot_free = !out_valid || out_ready;
  assign hs        = out_valid && out_ready;
  assign sel_lit   = lit_arr[sel];
  assign busy      = (state == S_RUN) || (state == S_DRAIN);
  assign halted    = (state == S_HALT);

  // Scan from the highest offset down so the nearest requester to rr_ptr
  // is the one left standing.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    for (int i = NUM_ENG - 1; i >= 0; i--) begin
      if (req[wrap_add(rr_ptr, i)]) begin
        found = 1'b1;
        sel   = wrap_add(rr_ptr, i);
      end
    end
  end

`ifdef UC_RR_SCHED_DEDUP_EN
  logic [LIT_W-1:0] last_lit;
  logic             last_vld;
  logic             last_clr;

  assign last_clr = (state == S_IDLE);
  assign dup      = last_vld && (sel_lit == last_lit);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_lit <= '0;
      last_vld <= 1'b0;
    end else if (last_clr) begin
      last_vld <= 1'b0;
    end else if (load) begin
      last_lit <= sel_lit;
      last_vld <= 1'b1;
    end
  end
`else
  assign dup = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Precedence inside RUN: conflict, then stop, then a normal grant.
  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    load      = 1'b0;
    valid_nxt = out_valid;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    case (state)
      S_IDLE: begin
        valid_nxt = 1'b0;
        if (start) begin
          state_nxt = S_RUN;
          cnt_clr   = 1'b1;
        end
      end
      S_RUN: begin
        if (conflict) begin
          state_nxt = S_HALT;
          valid_nxt = 1'b0;
        end else begin
          cnt_inc = hs;
          if (stop) begin
            state_nxt = S_DRAIN;
            if (hs) valid_nxt = 1'b0;
          end else if (slot_free) begin
            if (found) begin
              grant     = 1'b1;
              load      = !dup;
              valid_nxt = !dup;
            end else begin
              valid_nxt = 1'b0;
            end
          end
        end
      end
      S_DRAIN: begin
        if (conflict) begin
          state_nxt = S_HALT;
          valid_nxt = 1'b0;
        end else begin
          cnt_inc = hs;
          if (slot_free) begin
            state_nxt = S_IDLE;
            valid_nxt = 1'b0;
          end
        end
      end
      S_HALT: begin
        valid_nxt = 1'b0;
      end
      default: begin
        state_nxt = S_IDLE;
        valid_nxt = 1'b0;
      end
    endcase
  end

  always_comb begin
    eng_pop = '0;
    if (grant) eng_pop[sel] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_lit   <= '0;
      grant_idx <= '0;
      rr_ptr    <= '0;
      fwd_cnt   <= '0;
    end else begin
      out_valid <= valid_nxt;
      if (load) out_lit <= sel_lit;
      if (cnt_clr) begin
        rr_ptr  <= '0;
        fwd_cnt <= '0;
      end else begin
        if (grant) begin
          grant_idx <= sel;
          rr_ptr    <= wrap_add(sel, 1);
        end
        if (cnt_inc && fwd_cnt != 16'hFFFF) fwd_cnt <= fwd_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_uc_rr_sched.sv
module tb_uc_rr_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        conflict = 1'b0;
  logic [3:0]  eng_empty = 4'hF;
  logic [31:0] eng_lit = '0;
  logic [3:0]  eng_pop;
  logic        out_valid;
  logic [7:0]  out_lit;
  logic        out_ready = 1'b0;
  logic [1:0]  grant_idx;
  logic        busy;
  logic        halted;
  logic [15:0] fwd_cnt;

  int checks = 0;
  int failures = 0;

  logic [7:0] q [4][$];

  uc_rr_sched #(.NUM_ENG(4), .LIT_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .conflict(conflict),
    .eng_empty(eng_empty), .eng_lit(eng_lit), .eng_pop(eng_pop),
    .out_valid(out_valid), .out_lit(out_lit), .out_ready(out_ready),
    .grant_idx(grant_idx), .busy(busy), .halted(halted), .fwd_cnt(fwd_cnt)
  );

  always #5 clk = ~clk;

  task automatic refresh();
    for (int i = 0; i < 4; i++) begin
      eng_empty[i] = (q[i].size() == 0);
      eng_lit[i*8 +: 8] = (q[i].size() != 0) ? q[i][0] : 8'h00;
    end
  endtask

  task automatic clear_q();
    for (int i = 0; i < 4; i++) q[i].delete();
    refresh();
  endtask

  // Called at a negedge: latch the pop strobe, let the edge happen, then
  // retire popped heads from the modelled engine queues.
  task automatic tick();
    logic [3:0] p;
    p = eng_pop;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      if (p[i]) begin
        checks++;
        if (q[i].size() == 0) begin
          failures++;
          $display("FAIL pop_empty engine=%0d popped while empty", i);
        end else begin
          void'(q[i].pop_front());
        end
      end
    end
    refresh();
  endtask

  task automatic begin_run();
    start = 1'b1;
    @(negedge clk);
    tick();
    start = 1'b0;
  endtask

  task automatic end_run();
    bit done;
    done = 1'b0;
    out_ready = 1'b1;
    stop = 1'b1;
    @(negedge clk);
    tick();
    stop = 1'b0;
    for (int i = 0; i < 10 && !done; i++) begin
      @(negedge clk);
      if (!busy) done = 1'b1;
      else tick();
    end
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL end_run_timeout busy=%0b required 0", busy);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    clear_q();
    q[0].push_back(8'h11);
    refresh();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got=%0b exp=0", out_valid); end
    checks++; if (out_lit !== 8'h00) begin failures++; $display("FAIL rst_out_lit got=%0h exp=0", out_lit); end
    checks++; if (eng_pop !== 4'h0) begin failures++; $display("FAIL rst_eng_pop got=%0b exp=0", eng_pop); end
    checks++; if (grant_idx !== 2'd0) begin failures++; $display("FAIL rst_grant_idx got=%0d exp=0", grant_idx); end
    checks++; if (busy !== 1'b0 || halted !== 1'b0) begin failures++; $display("FAIL rst_busy_halted got=%0b%0b exp=00", busy, halted); end
    checks++; if (fwd_cnt !== 16'd0) begin failures++; $display("FAIL rst_fwd_cnt got=%0d exp=0", fwd_cnt); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (eng_pop !== 4'h0) begin failures++; $display("FAIL idle_no_pop got=%0b exp=0", eng_pop); end
    tick();
  endtask

  task automatic test_fairness();
    clear_q();
    for (int i = 0; i < 4; i++) begin
      q[i].push_back(8'(i + 1));
      q[i].push_back(8'(i + 1));
    end
    refresh();
    out_ready = 1'b1;
    begin_run();
    @(negedge clk);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL start_busy got=%0b exp=1", busy); end
    for (int k = 0; k < 8; k++) begin
      if (k > 0) @(negedge clk);
      checks++;
      if (eng_pop !== 4'(1 << (k % 4))) begin failures++; $display("FAIL fair_pop step=%0d got=%0b exp=%0b", k, eng_pop, 4'(1 << (k % 4))); end
      if (k > 0) begin
        checks++;
        if (out_valid !== 1'b1 || out_lit !== 8'((k - 1) % 4 + 1) || grant_idx !== 2'((k - 1) % 4)) begin
          failures++;
          $display("FAIL fair_out step=%0d got v=%0b lit=%0d g=%0d exp v=1 lit=%0d g=%0d", k, out_valid, out_lit, grant_idx, (k - 1) % 4 + 1, (k - 1) % 4);
        end
      end
      tick();
    end
    @(negedge clk);
    checks++;
    if (out_lit !== 8'd4 || grant_idx !== 2'd3 || eng_pop !== 4'h0 || fwd_cnt !== 16'd7) begin
      failures++;
      $display("FAIL fair_tail got lit=%0d g=%0d pop=%0b cnt=%0d exp lit=4 g=3 pop=0 cnt=7", out_lit, grant_idx, eng_pop, fwd_cnt);
    end
    tick();
    end_run();
  endtask

  task automatic test_skip_wrap();
    clear_q();
    q[0].push_back(8'd10);
    q[1].push_back(8'd11);
    q[2].push_back(8'd12);
    refresh();
    out_ready = 1'b1;
    begin_run();
    repeat (3) begin
      @(negedge clk);
      tick();
    end
    q[1].push_back(8'd21);
    q[3].push_back(8'd23);
    refresh();
    @(negedge clk);
    checks++;
    if (grant_idx !== 2'd2 || eng_pop !== 4'b1000) begin failures++; $display("FAIL skip_first got g=%0d pop=%0b exp g=2 pop=1000", grant_idx, eng_pop); end
    tick();
    @(negedge clk);
    checks++;
    if (eng_pop !== 4'b0010 || out_lit !== 8'd23 || grant_idx !== 2'd3) begin failures++; $display("FAIL skip_wrap got pop=%0b lit=%0d g=%0d exp pop=0010 lit=23 g=3", eng_pop, out_lit, grant_idx); end
    tick();
    @(negedge clk);
    checks++;
    if (out_lit !== 8'd21 || grant_idx !== 2'd1) begin failures++; $display("FAIL skip_last got lit=%0d g=%0d exp lit=21 g=1", out_lit, grant_idx); end
    tick();
    end_run();
  endtask

  task automatic test_back_pressure();
    clear_q();
    q[0].push_back(8'hFB);
    q[1].push_back(8'd9);
    refresh();
    out_ready = 1'b0;
    begin_run();
    @(negedge clk);
    checks++; if (eng_pop !== 4'b0001) begin failures++; $display("FAIL bp_first_pop got=%0b exp=0001", eng_pop); end
    tick();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (eng_pop !== 4'h0 || out_valid !== 1'b1 || out_lit !== 8'hFB) begin
        failures++;
        $display("FAIL bp_hold cycle=%0d got pop=%0b v=%0b lit=%0h exp pop=0 v=1 lit=fb", k, eng_pop, out_valid, out_lit);
      end
      tick();
    end
    out_ready = 1'b1;
    @(negedge clk);
    checks++; if (eng_pop !== 4'b0010) begin failures++; $display("FAIL bp_release_pop got=%0b exp=0010", eng_pop); end
    tick();
    @(negedge clk);
    checks++;
    if (fwd_cnt !== 16'd1 || out_lit !== 8'd9) begin failures++; $display("FAIL bp_after got cnt=%0d lit=%0d exp cnt=1 lit=9", fwd_cnt, out_lit); end
    tick();
    end_run();
  endtask

  task automatic test_conflict();
    clear_q();
    q[0].push_back(8'd3);
    q[0].push_back(8'd5);
    q[1].push_back(8'd6);
    refresh();
    out_ready = 1'b1;
    begin_run();
    @(negedge clk);
    tick();
    conflict = 1'b1;
    @(negedge clk);
    checks++; if (eng_pop !== 4'h0) begin failures++; $display("FAIL conf_no_pop got=%0b exp=0", eng_pop); end
    tick();
    conflict = 1'b0;
    @(negedge clk);
    checks++;
    if (halted !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || fwd_cnt !== 16'd0) begin
      failures++;
      $display("FAIL conf_halt got h=%0b v=%0b b=%0b cnt=%0d exp h=1 v=0 b=0 cnt=0", halted, out_valid, busy, fwd_cnt);
    end
    tick();
    start = 1'b1;
    @(negedge clk);
    tick();
    start = 1'b0;
    @(negedge clk);
    checks++;
    if (halted !== 1'b1 || busy !== 1'b0 || eng_pop !== 4'h0) begin
      failures++;
      $display("FAIL conf_sticky got h=%0b b=%0b pop=%0b exp h=1 b=0 pop=0", halted, busy, eng_pop);
    end
    rst = 1'b1;
    #1;
    checks++; if (halted !== 1'b0) begin failures++; $display("FAIL conf_rst_exit got=%0b exp=0", halted); end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_stop_drain();
    clear_q();
    q[0].push_back(8'd40);
    q[1].push_back(8'd41);
    q[1].push_back(8'd42);
    refresh();
    out_ready = 1'b0;
    begin_run();
    @(negedge clk);
    tick();
    stop = 1'b1;
    @(negedge clk);
    checks++; if (eng_pop !== 4'h0) begin failures++; $display("FAIL stop_no_pop got=%0b exp=0", eng_pop); end
    tick();
    stop = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checks++;
      if (busy !== 1'b1 || eng_pop !== 4'h0 || out_valid !== 1'b1 || out_lit !== 8'd40) begin
        failures++;
        $display("FAIL drain_hold cycle=%0d got b=%0b pop=%0b v=%0b lit=%0d exp b=1 pop=0 v=1 lit=40", k, busy, eng_pop, out_valid, out_lit);
      end
      tick();
    end
    out_ready = 1'b1;
    @(negedge clk);
    checks++; if (eng_pop !== 4'h0) begin failures++; $display("FAIL drain_release_pop got=%0b exp=0", eng_pop); end
    tick();
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || fwd_cnt !== 16'd1 || halted !== 1'b0) begin
      failures++;
      $display("FAIL drain_idle got b=%0b v=%0b cnt=%0d h=%0b exp b=0 v=0 cnt=1 h=0", busy, out_valid, fwd_cnt, halted);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_async_reset();
    clear_q();
    q[2].push_back(8'h33);
    refresh();
    out_ready = 1'b0;
    begin_run();
    @(negedge clk);
    tick();
    @(negedge clk);
    checks++;
    if (grant_idx !== 2'd2 || out_valid !== 1'b1 || out_lit !== 8'h33) begin
      failures++;
      $display("FAIL arst_pre got g=%0d v=%0b lit=%0h exp g=2 v=1 lit=33", grant_idx, out_valid, out_lit);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_lit !== 8'h00 || grant_idx !== 2'd0 || busy !== 1'b0 || eng_pop !== 4'h0) begin
      failures++;
      $display("FAIL arst_now got v=%0b lit=%0h g=%0d b=%0b pop=%0b exp all 0", out_valid, out_lit, grant_idx, busy, eng_pop);
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_dedup();
    int exp_cnt;
`ifdef UC_RR_SCHED_DEDUP_EN
    exp_cnt = 1;
`else
    exp_cnt = 2;
`endif
    clear_q();
    q[0].push_back(8'd7);
    q[1].push_back(8'd7);
    refresh();
    out_ready = 1'b1;
    begin_run();
    repeat (4) begin
      @(negedge clk);
      tick();
    end
    @(negedge clk);
    checks++;
    if (q[0].size() != 0 || q[1].size() != 0 || int'(fwd_cnt) != exp_cnt) begin
      failures++;
      $display("FAIL dedup got q0=%0d q1=%0d cnt=%0d exp q0=0 q1=0 cnt=%0d", q[0].size(), q[1].size(), fwd_cnt, exp_cnt);
    end
    @(posedge clk); #1;
    end_run();
  endtask

  task automatic test_random();
    logic [7:0] exp_lit [$];
    int         exp_eng [$];
    logic [7:0] mq [4][$];
    logic [7:0] v;
    logic [7:0] last;
    logic [7:0] held;
    logic [3:0] exp_pop;
    bit         last_v;
    bit         held_v;
    bit         done;
    bit         slot_free;
    bit         any;
    int         ptr;
    int         pick;
    int         rcv;
    int         pidx;
    for (int it = 0; it < 6; it++) begin
      exp_lit.delete();
      exp_eng.delete();
      clear_q();
      for (int i = 0; i < 4; i++) begin
        mq[i].delete();
        for (int j = 0; j < int'($urandom_range(0, 6)); j++) begin
          v = 8'($urandom);
          q[i].push_back(v);
          mq[i].push_back(v);
        end
      end
      refresh();
      ptr = 0;
      last_v = 1'b0;
      last = 8'h00;
      for (int g = 0; g < 32; g++) begin
        pick = -1;
        for (int k = 0; k < 4; k++)
          if (pick < 0 && mq[(ptr + k) % 4].size() > 0) pick = (ptr + k) % 4;
        if (pick >= 0) begin
          exp_eng.push_back(pick);
          v = mq[pick].pop_front();
          ptr = (pick + 1) % 4;
`ifdef UC_RR_SCHED_DEDUP_EN
          if (!(last_v && v == last)) exp_lit.push_back(v);
`else
          exp_lit.push_back(v);
`endif
          last = v;
          last_v = 1'b1;
        end
      end
      out_ready = 1'b0;
      begin_run();
      rcv = 0;
      pidx = 0;
      held_v = 1'b0;
      held = 8'h00;
      done = 1'b0;
      for (int cyc = 0; cyc < 400 && !done; cyc++) begin
        out_ready = ($urandom_range(0, 9) < 6);
        @(negedge clk);
        if (rcv == exp_lit.size() && pidx == exp_eng.size() && !out_valid) begin
          done = 1'b1;
        end else begin
          slot_free = !out_valid || out_ready;
          any = (eng_empty != 4'hF);
          checks++;
          if ((eng_pop != 4'h0) != (slot_free && any)) begin
            failures++;
            $display("FAIL rand_pop_req it=%0d got pop=%0b exp active=%0b", it, eng_pop, slot_free && any);
          end
          if (eng_pop != 4'h0) begin
            exp_pop = (pidx < exp_eng.size()) ? 4'(1 << exp_eng[pidx]) : 4'h0;
            checks++;
            if (eng_pop !== exp_pop) begin
              failures++;
              $display("FAIL rand_pop_order it=%0d n=%0d got=%0b exp=%0b", it, pidx, eng_pop, exp_pop);
            end
            pidx++;
          end
          if (held_v) begin
            checks++;
            if (out_valid !== 1'b1 || out_lit !== held) begin
              failures++;
              $display("FAIL rand_hold it=%0d got v=%0b lit=%0h exp v=1 lit=%0h", it, out_valid, out_lit, held);
            end
          end
          if (out_valid && out_ready) begin
            checks++;
            if (rcv >= exp_lit.size()) begin
              failures++;
              $display("FAIL rand_extra it=%0d got lit=%0h exp none", it, out_lit);
            end else if (out_lit !== exp_lit[rcv]) begin
              failures++;
              $display("FAIL rand_lit it=%0d n=%0d got=%0h exp=%0h", it, rcv, out_lit, exp_lit[rcv]);
            end
            rcv++;
          end
          held_v = out_valid && !out_ready;
          held = out_lit;
          tick();
        end
      end
      checks++;
      if (!done) begin
        failures++;
        $display("FAIL rand_timeout it=%0d got rcv=%0d pops=%0d exp rcv=%0d pops=%0d", it, rcv, pidx, exp_lit.size(), exp_eng.size());
      end
      checks++;
      if (int'(fwd_cnt) != exp_lit.size()) begin
        failures++;
        $display("FAIL rand_fwd_cnt it=%0d got=%0d exp=%0d", it, fwd_cnt, exp_lit.size());
      end
      @(posedge clk); #1;
      end_run();
    end
  endtask

  initial begin
    refresh();
    test_reset();
    test_fairness();
    test_skip_wrap();
    test_back_pressure();
    test_conflict();
    test_stop_drain();
    test_async_reset();
    test_dedup();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
